// File: rtl/demux8_deser.sv
// Serial-to-parallel lane demultiplexer: routes single bits into an 8-lane frame
// and publishes the frame on out when every lane has been written once.
module demux8_deser (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_bit,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] sel,
    input  logic       auto,
    input  logic       flush,
    output logic [7:0] out,
    output logic       out_valid,
    output logic [7:0] lane_mask,
    output logic       err_dup
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } state_t;

    state_t     state;
    logic [7:0] frame;
    logic [2:0] ptr;

    logic [2:0] lane;
    logic [7:0] lane_bit;
    logic [7:0] next_mask;
    logic [7:0] next_frame;

    // NOTE: every always_comb output is assigned on every path so no latch is inferred.
    always_comb begin
        lane       = auto ? ptr : sel;
        lane_bit   = 8'h01 << lane;
        next_mask  = lane_mask | lane_bit;
        next_frame = in_bit ? (frame | lane_bit) : (frame & ~lane_bit);
    end

    // The cycle after a completion is a dead cycle so the consumer sees out settle.
    assign in_ready = (state != DONE);

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            frame     <= 8'h00;
            ptr       <= 3'd0;
            lane_mask <= 8'h00;
            out       <= 8'h00;
            out_valid <= 1'b0;
            err_dup   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            err_dup   <= 1'b0;
            if (flush) begin
                state     <= IDLE;
                frame     <= 8'h00;
                ptr       <= 3'd0;
                lane_mask <= 8'h00;
            end else if (state == DONE) begin
                state <= IDLE;
            end else if (in_valid) begin
                err_dup <= lane_mask[lane];
                if (next_mask == 8'hFF) begin
                    out       <= next_frame;
                    out_valid <= 1'b1;
                    frame     <= 8'h00;
                    ptr       <= 3'd0;
                    lane_mask <= 8'h00;
                    state     <= DONE;
                end else begin
                    frame     <= next_frame;
                    lane_mask <= next_mask;
                    if (auto) begin
                        ptr <= ptr + 3'd1;
                    end
                    state <= FILL;
                end
            end
        end
    end

endmodule

// File: doc/demux8_deser.md
DEMUX8_DESER -- requirements
Module: demux8_deser

Interface
REQ-001 Module SHALL be named demux8_deser, with one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 in_bit  input  1  data bit to route to one output lane.
REQ-005 in_valid  input  1  in_bit/sel valid this cycle.
REQ-006 in_ready  output  1  block accepts a write this cycle; write occurs when in_valid && in_ready.
REQ-007 sel  input  3  destination lane when auto=0.
REQ-008 auto  input  1  1 = ignore sel and use internal lane pointer ptr; 0 = use sel.
REQ-009 flush  input  1  abandon the current partial frame.
REQ-010 out  output  8  last completed frame, registered; lane k = out[k].
REQ-011 out_valid  output  1  one-cycle pulse, new frame on out.
REQ-012 lane_mask  output  8  lanes written in the current frame.
REQ-013 err_dup  output  1  one-cycle pulse, previous write hit an already-written lane.

Function
REQ-014 SHALL use states IDLE (mask=0), FILL (0<mask<FF), and DONE (one cycle after a frame completes).
REQ-015 in_ready SHALL be 1 in IDLE and FILL, and 0 in DONE.
REQ-016 An accepted write SHALL target lane L = auto ? ptr : sel, set frame[L] <= in_bit, and set lane_mask[L] <= 1.
REQ-017 In auto mode, ptr SHALL increment by 1 per accepted write, wrapping 7 -> 0; in sel mode, ptr SHALL be unchanged.
REQ-018 An IDLE accepted write SHALL move the state to FILL, unless it completes the mask.
REQ-019 Completion: when the accepted write makes lane_mask == 8'hFF, then at the same edge:
- out SHALL load frame including the new bit;
- out_valid SHALL be 1 for the following cycle;
- lane_mask, frame and ptr SHALL clear;
- state SHALL move to DONE.
REQ-020 DONE SHALL always return to IDLE after exactly one cycle; in_valid in DONE SHALL be ignored, with no state change.
REQ-021 A write to a lane whose mask bit is already 1 SHALL overwrite the bit, leave the mask unchanged, and pulse err_dup the next cycle.
REQ-022 flush SHALL, at the next edge:
- clear lane_mask, frame and ptr;
- move the state to IDLE;
- leave out unchanged and emit no out_valid.
REQ-023 flush asserted together with in_valid SHALL take priority, and the write SHALL be dropped.
REQ-024 A mid-frame change of auto SHALL take effect on the next write; ptr SHALL retain its value.
REQ-025 out SHALL hold its value between completions, independent of in_bit/sel activity.
REQ-026 Latency from the 8th accepted write edge to out/out_valid visible SHALL be 1 cycle.

Reset
REQ-027 When rst=1 at an edge, the block SHALL set:
- out=8'h00, out_valid=0, err_dup=0;
- lane_mask=8'h00, frame=0, ptr=0;
- state IDLE, so in_ready=1 after reset.
REQ-028 rst SHALL take priority over flush and in_valid.
REQ-029 rst mid-frame SHALL discard the partial frame with no out_valid.

Verification
REQ-030 Auto mode, bits 1,0,1,1,0,0,1,0 on consecutive cycles -> out=8'h4D, out_valid single pulse one cycle after the 8th write, then in_ready=0 for 1 cycle.
REQ-031 Sel mode, lanes 7..0 descending with in_bit=1 except lane 3=0 -> out=8'hF7, lane_mask steps 80,C0,...,FF->00.
REQ-032 Sel mode, write lane 2 with 1 then lane 2 with 0 -> err_dup pulse, lane_mask=8'h04, frame[2]=0.
REQ-033 Write 5 lanes, then flush with in_valid=1 -> lane_mask=00, out unchanged, no out_valid, next auto write lands in lane 0.
REQ-034 Back-to-back frames with in_valid held high -> DONE-cycle write dropped, second frame completes 9 cycles after the first.
REQ-035 rst after 6 auto writes -> all outputs zero, and the next 8 writes produce a clean frame.
